// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with byte hold/accept handshake
//
// Purpose: receives 8N1 frames (start, 8 data bits LSB first, stop) from an
// asynchronous serial line. The received byte is held with o_done until the
// consumer acknowledges it with i_byte_accept.
//
// Optional feature: define UART_RX_OVERRUN_EN to add the o_overrun output,
// which flags a frame start seen while a byte was still held.
//
// Ports:
//   i_clk          in   1  system clock, rising edge
//   i_rst_n        in   1  asynchronous active-low reset
//   i_byte_accept  in   1  consumer acknowledge (pulse or level)
//   i_data_bit     in   1  serial RX line, asynchronous, idles high
//   o_done         out  1  high while a received byte is held
//   o_data_byte    out  8  received byte, valid while o_done=1
//   framing_error  out  1  stop bit of the held frame was 0
//   o_overrun      out  1  (UART_RX_OVERRUN_EN only) frame dropped while held

module uart_rx #(
  parameter int clk_frequency = 27,
  parameter int baud_rate     = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_byte_accept,
  input  logic       i_data_bit,
`ifdef UART_RX_OVERRUN_EN
  output logic       o_overrun,
`endif
  output logic       o_done,
  output logic [7:0] o_data_byte,
  output logic       framing_error
);

  localparam int CYCLES_PER_BIT = (clk_frequency * 1_000_000) / baud_rate;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CW             = (CYCLES_PER_BIT > 2) ? $clog2(CYCLES_PER_BIT) : 1;

  localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLES_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  logic          sync1;
  logic          sync2;
  logic          sync_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          fall;

  // Start detection needs a real 1->0 edge; a line held low never re-arms.
  assign fall = sync_prev & ~sync2;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      sync1         <= 1'b1;
      sync2         <= 1'b1;
      sync_prev     <= 1'b1;
      cnt           <= '0;
      bit_idx       <= 3'd0;
      shift         <= 8'h00;
      o_done        <= 1'b0;
      o_data_byte   <= 8'h00;
      framing_error <= 1'b0;
`ifdef UART_RX_OVERRUN_EN
      o_overrun     <= 1'b0;
`endif
    end else begin
      sync1     <= i_data_bit;
      sync2     <= sync1;
      sync_prev <= sync2;

      unique case (state)
        IDLE: begin
          if (fall) begin
            bit_idx <= 3'd0;
            cnt     <= '0;
            state   <= START;
          end
        end

        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            // A start bit that is high again at its middle was a glitch.
            state <= sync2 ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            shift <= {sync2, shift[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt           <= '0;
            o_data_byte   <= shift;
            framing_error <= ~sync2;
            o_done        <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          if (i_byte_accept) begin
            o_done        <= 1'b0;
            framing_error <= 1'b0;
`ifdef UART_RX_OVERRUN_EN
            o_overrun     <= 1'b0;
`endif
            state         <= IDLE;
          end
`ifdef UART_RX_OVERRUN_EN
          else if (fall) begin
            o_overrun <= 1'b1;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (table vectors + scoreboard)

module tb_uart_rx;

  localparam int CLK_MHZ = 2;
  localparam int BAUD    = 125000;
  localparam int CPB     = (CLK_MHZ * 1_000_000) / BAUD;
  localparam int HALF    = CPB / 2;
  localparam int LAT     = HALF + 9 * CPB;

  logic       clk;
  logic       rst_n;
  logic       byte_accept;
  logic       rx;
  logic       o_done;
  logic [7:0] o_data_byte;
  logic       framing_error;
`ifdef UART_RX_OVERRUN_EN
  logic       o_overrun;
`endif

  uart_rx #(
    .clk_frequency(CLK_MHZ),
    .baud_rate    (BAUD)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_byte_accept(byte_accept),
    .i_data_bit   (rx),
`ifdef UART_RX_OVERRUN_EN
    .o_overrun    (o_overrun),
`endif
    .o_done       (o_done),
    .o_data_byte  (o_data_byte),
    .framing_error(framing_error)
  );

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         idle_bits;
    logic       exp_fe;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   start_cyc = 0;
  logic auto_accept = 1'b0;
  logic accept_now  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int idle_bits);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
    for (int i = 0; i < idle_bits; i++) send_bit(1'b1);
  endtask

  task automatic wait_drained(input string name, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    check(name, sb.size(), 0);
  endtask

  task automatic do_accept(input string name);
    accept_now = 1'b1;
    for (int i = 0; i < 8 && o_done; i++) @(negedge clk);
    check(name, {31'd0, o_done}, 0);
    accept_now = 1'b0;
  endtask

  // Acceptor: single driver of byte_accept, one-cycle pulses.
  initial begin : acceptor
    byte_accept = 1'b0;
    forever begin
      @(negedge clk);
      if ((auto_accept || accept_now) && o_done && !byte_accept) byte_accept = 1'b1;
      else byte_accept = 1'b0;
    end
  end

  // Monitor: every rising o_done pops the scoreboard and compares.
  initial begin : monitor
    logic done_q;
    exp_t e;
    int   lat;
    done_q = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && o_done && !done_q) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_frame: got byte 0x%0h, none expected", o_data_byte);
        end else begin
          e = sb.pop_front();
          check("rx_byte", {24'd0, o_data_byte}, {24'd0, e.data});
          check("rx_fe", {31'd0, framing_error}, {31'd0, e.fe});
          lat = cyc - start_cyc;
          check("latency_in_window", {31'd0, (lat >= LAT + 2 && lat <= LAT + 4)}, 1);
        end
      end
      done_q = o_done;
    end
  end

  vec_t vecs[7];

  initial begin : main
    vecs[0] = '{data: 8'h5A, stop: 1'b1, idle_bits: 1, exp_fe: 1'b0};
    vecs[1] = '{data: 8'h5B, stop: 1'b0, idle_bits: 1, exp_fe: 1'b1};
    vecs[2] = '{data: 8'h5C, stop: 1'b1, idle_bits: 0, exp_fe: 1'b0};
    vecs[3] = '{data: 8'h5D, stop: 1'b1, idle_bits: 1, exp_fe: 1'b0};
    vecs[4] = '{data: 8'h00, stop: 1'b1, idle_bits: 1, exp_fe: 1'b0};
    vecs[5] = '{data: 8'hFF, stop: 1'b0, idle_bits: 2, exp_fe: 1'b1};
    vecs[6] = '{data: 8'h81, stop: 1'b1, idle_bits: 1, exp_fe: 1'b0};

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_done", {31'd0, o_done}, 0);
    check("reset_byte", {24'd0, o_data_byte}, 0);
    check("reset_fe", {31'd0, framing_error}, 0);
`ifdef UART_RX_OVERRUN_EN
    check("reset_overrun", {31'd0, o_overrun}, 0);
`endif
    rst_n = 1'b1;
    send_bit(1'b1);

    // Table: frames with auto-accept, including a back-to-back pair.
    auto_accept = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{data: vecs[i].data, fe: vecs[i].exp_fe});
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].idle_bits);
    end
    wait_drained("table_drained", 20 * CPB);
    repeat (4) @(negedge clk);
    check("table_done_cleared", {31'd0, o_done}, 0);

    // Short low glitch on an idle line must not start a frame.
    repeat (2 * CPB) @(negedge clk);
    rx = 1'b0;
    repeat (HALF - 3) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("glitch_no_done", {31'd0, o_done}, 0);
    sb.push_back('{data: 8'h3C, fe: 1'b0});
    send_frame(8'h3C, 1'b1, 1);
    wait_drained("after_glitch_frame", 20 * CPB);

    // Reset in the middle of the data bits aborts the frame.
    repeat (CPB) @(negedge clk);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (2) @(negedge clk);
    check("midreset_done", {31'd0, o_done}, 0);
    check("midreset_byte", {24'd0, o_data_byte}, 0);
    check("midreset_fe", {31'd0, framing_error}, 0);
    rst_n = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("midreset_no_report", {31'd0, o_done}, 0);
    sb.push_back('{data: 8'hA5, fe: 1'b0});
    send_frame(8'hA5, 1'b1, 1);
    wait_drained("after_reset_frame", 20 * CPB);

    // Bad stop bit with the line left low: accept must not re-arm on the low level.
    auto_accept = 1'b0;
    repeat (CPB) @(negedge clk);
    sb.push_back('{data: 8'hE7, fe: 1'b1});
    send_frame(8'hE7, 1'b0, 0);
    rx = 1'b0;
    wait_drained("low_stop_frame", 4 * CPB);
    check("low_stop_held", {31'd0, o_done}, 1);
    do_accept("low_stop_accept");
    repeat (3 * CPB) @(negedge clk);
    check("low_line_no_frame", {31'd0, o_done}, 0);
    rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("line_release_no_frame", {31'd0, o_done}, 0);

    // Hold: a second frame while DONE is dropped; the held byte stays.
    sb.push_back('{data: 8'h11, fe: 1'b0});
    send_frame(8'h11, 1'b1, 1);
    wait_drained("hold_first", 4 * CPB);
    send_frame(8'h22, 1'b1, 2);
    check("hold_done", {31'd0, o_done}, 1);
    check("hold_byte", {24'd0, o_data_byte}, 32'h11);
    check("hold_fe", {31'd0, framing_error}, 0);
`ifdef UART_RX_OVERRUN_EN
    check("overrun_set", {31'd0, o_overrun}, 1);
`endif
    do_accept("hold_accept");
    check("accept_byte_holds", {24'd0, o_data_byte}, 32'h11);
`ifdef UART_RX_OVERRUN_EN
    check("overrun_cleared", {31'd0, o_overrun}, 0);
`endif
    repeat (12 * CPB) @(negedge clk);
    check("dropped_not_reported", {31'd0, o_done}, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver: one start bit, 8 data bits LSB first, one stop bit, no parity.
- Converts the serial line i_data_bit into a parallel byte.
- Holds the byte with o_done until the consumer acknowledges with i_byte_accept.
- Sits between the board RX pin and the downstream byte consumer, in the i_clk domain.

Parameters:
- clk_frequency, 27, system clock frequency in MHz (integer).
- baud_rate, 115200, serial bit rate in bits/s.
- Derived constant CYCLES_PER_BIT = (clk_frequency*1_000_000)/baud_rate, truncated; 234 at defaults.
- Derived constant HALF_BIT = CYCLES_PER_BIT/2, truncated; 117 at defaults.

Ports:
- i_clk  input  1  system clock, rising-edge active.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_byte_accept  input  1  consumer acknowledge; one-cycle pulse or level.
- i_data_bit  input  1  serial RX line; asynchronous; idles high.
- o_done  output  1  high while a received byte is held.
- o_data_byte  output  8  received byte; valid while o_done=1.
- framing_error  output  1  stop bit of the held frame was sampled 0; valid while o_done=1.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Asserting i_rst_n=0 forces state IDLE and clears o_done, o_data_byte (8'h00), framing_error, all counters and the shift register.
  - Reset mid-frame aborts the frame; nothing is reported.
- Synchronizer: i_data_bit passes through a 2-flop synchronizer; the synchronizer flops reset to 1. A third registered copy is used for edge detection. All decisions use the synchronized value.
- IDLE:
  - Waits for a 1->0 transition of the synchronized line; a line that is merely held low is not a start.
  - On the transition: clear the bit counter and go to START.
- START:
  - After HALF_BIT cycles, sample the line.
  - 0: go to DATA and restart the cycle counter.
  - 1: treat as a glitch and return to IDLE.
- DATA:
  - Sample every CYCLES_PER_BIT cycles, so each sample falls at mid-bit.
  - Shift LSB first: first sample -> bit0, eighth sample -> bit7.
  - After the 8th sample go to STOP.
- STOP: after CYCLES_PER_BIT cycles, sample the stop bit.
  - Load o_data_byte with the assembled byte.
  - Set framing_error = NOT(sample).
  - Set o_done=1 on the next clock edge; enter DONE.
  - A bad stop bit still delivers the byte.
- DONE:
  - Outputs hold.
  - The line is ignored; a frame arriving while DONE is lost.
  - On i_byte_accept=1 at a clock edge: o_done and framing_error clear, o_data_byte holds its value, go to IDLE. DONE->IDLE takes exactly 1 cycle.
  - Re-arming in IDLE still requires a fresh 1->0 edge, so a low bad-stop bit persisting after accept does not start a frame.
- i_byte_accept outside DONE is ignored.
- Latency: o_done rises HALF_BIT + 9*CYCLES_PER_BIT + about 3 cycles after the start edge, i.e. mid stop bit.
- Back-to-back frames: accepting in the second half of the stop bit lets the next start bit, which follows the stop bit directly, be received.
- Counter width: enough bits for CYCLES_PER_BIT-1; the bit index is 3 bits.

Optional Feature:
- Macro UART_RX_OVERRUN_EN.
- Defined:
  - Adds output o_overrun (1 bit), reset 0.
  - Set to 1 when a 1->0 line edge occurs while in DONE; the frame is still dropped.
  - Cleared on the accepting i_byte_accept.
- Undefined: no o_overrun port; the edge in DONE is silently ignored.

Test Plan:
- Line held at 1 for 1 bit time, then start bit, data 8'h5A LSB first, stop=1, 1 idle bit -> o_done=1, o_data_byte=8'h5A, framing_error=0. After an accept pulse, o_done=0.
- Same framing with data 8'h5B and stop bit driven 0, then 1 idle bit -> o_done=1, framing_error=1. After accept, o_done=0 and no spurious frame follows.
- Frame 8'h5C with no trailing idle, accept pulse at o_done, then immediately frame 8'h5D -> both received correctly with framing_error=0.
- Low pulse of fewer than HALF_BIT cycles on an idle line -> return to IDLE; o_done stays 0.
- i_rst_n asserted mid-data of a frame, then released -> all outputs 0; the next full frame 8'hA5 is received correctly.
- With UART_RX_OVERRUN_EN: send 8'h11, do not accept, send 8'h22 -> o_data_byte stays 8'h11 and o_overrun=1. After accept, o_overrun=0.
